demux_1to8_16bits_reg: RTL and testbench

//  Registered 1-to-8 distributor for 16-bit words; the write-side counterpart of mux_8to1_16bits.

---
 rtl/demux_1to8_16bits_reg_pkg.sv | 22 ++
 rtl/demux_1to8_16bits_reg_lane.sv | 34 +++
 rtl/demux_1to8_16bits_reg.sv | 71 +++++++
 tb/tb_demux_1to8_16bits_reg.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_1to8_16bits_reg_pkg.sv
// Shared constants, lane record type and select decoder for the 1-to-8 word distributor.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package demux_1to8_16bits_reg_pkg;

    localparam int DATA_W = 16;
    localparam int SEL_W  = 3;
    localparam int LANES  = 8;
    localparam int CNT_W  = 16;

    // One lane's holding state: the word and its unconsumed flag.
    typedef struct packed {
        logic              vld;
        logic [DATA_W-1:0] dat;
    } lane_t;

    // 3-to-8 one-hot decode of the destination select.
    function automatic logic [LANES-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        return LANES'(1) << sel;
    endfunction

endpackage

// File: rtl/demux_1to8_16bits_reg_lane.sv
// One output lane: a 16-bit holding register plus its full flag.
// Latency: write visible one cycle after we; ack clears the flag one cycle later.
// Backpressure: none here; the top uses vld/ack to gate writes into this lane.
module demux_lane_16bits
    import demux_1to8_16bits_reg_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              ack,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] dat,
    output logic              vld
);

    lane_t lane_q;

    // A write wins over a same-cycle ack so a drained lane refills without a bubble;
    // the data word is only ever cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_q <= '0;
        end else if (we) begin
            lane_q.dat <= in_data;
            lane_q.vld <= 1'b1;
        end else if (ack) begin
            lane_q.vld <= 1'b0;
        end
    end

    assign dat = lane_q.dat;
    assign vld = lane_q.vld;

endmodule

// File: rtl/demux_1to8_16bits_reg.sv
// Registered 1-to-8 distributor: steers each accepted word into the lane picked by b.
// Latency: one cycle from transfer to out<b>/out_vld[b]; wr_cnt updates on the same edge.
// Backpressure: in_rdy drops only when the addressed lane is full and not being acked this cycle.
module demux_1to8_16bits_reg
    import demux_1to8_16bits_reg_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  b,
    input  logic              in_vld,
    output logic              in_rdy,
    output logic [DATA_W-1:0] out0,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    output logic [DATA_W-1:0] out3,
    output logic [DATA_W-1:0] out4,
    output logic [DATA_W-1:0] out5,
    output logic [DATA_W-1:0] out6,
    output logic [DATA_W-1:0] out7,
    output logic [LANES-1:0]  out_vld,
    input  logic [LANES-1:0]  out_ack,
    output logic [CNT_W-1:0]  wr_cnt
);

    logic [LANES-1:0]  lane_vld;
    logic [DATA_W-1:0] lane_dat [LANES];
    logic [LANES-1:0]  lane_we;
    logic              xfer;

    // Readiness looks only at the addressed lane; an ack on that lane frees it this cycle.
    always_comb begin
        in_rdy  = rst_n & (~lane_vld[b] | out_ack[b]);
        xfer    = in_vld & in_rdy;
        lane_we = sel_onehot(b) & {LANES{xfer}};
    end

    generate
        for (genvar k = 0; k < LANES; k++) begin : lanes
            demux_lane_16bits u_lane (
                .clk     (clk),
                .rst_n   (rst_n),
                .we      (lane_we[k]),
                .ack     (out_ack[k]),
                .in_data (in_data),
                .dat     (lane_dat[k]),
                .vld     (lane_vld[k])
            );
        end
    endgenerate

    // Count of accepted words; wraps naturally at the counter width.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt <= '0;
        end else if (xfer) begin
            wr_cnt <= wr_cnt + CNT_W'(1);
        end
    end

    assign out_vld = lane_vld;
    assign out0    = lane_dat[0];
    assign out1    = lane_dat[1];
    assign out2    = lane_dat[2];
    assign out3    = lane_dat[3];
    assign out4    = lane_dat[4];
    assign out5    = lane_dat[5];
    assign out6    = lane_dat[6];
    assign out7    = lane_dat[7];

endmodule

// File: tb/tb_demux_1to8_16bits_reg.sv
// Bench for the 1-to-8 registered distributor: directed scenarios plus a random phase.
// Expected outputs come from a lane-array model of the behaviour rules.
// Source holds word and select while stalled, as a well-behaved producer must.
module tb_demux_1to8_16bits_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_data;
    logic [2:0]  b;
    logic        in_vld;
    logic        in_rdy;
    logic [15:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic [7:0]  out_vld;
    logic [7:0]  out_ack;
    logic [15:0] wr_cnt;

    logic [15:0] outs [8];

    // Reference model: what each lane holds, whether it is full, and the accepted-word count.
    logic [15:0] m_dat [8];
    logic        m_full [8];
    int unsigned m_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    demux_1to8_16bits_reg dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_data (in_data),
        .b       (b),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .out0    (out0),
        .out1    (out1),
        .out2    (out2),
        .out3    (out3),
        .out4    (out4),
        .out5    (out5),
        .out6    (out6),
        .out7    (out7),
        .out_vld (out_vld),
        .out_ack (out_ack),
        .wr_cnt  (wr_cnt)
    );

    assign outs[0] = out0;
    assign outs[1] = out1;
    assign outs[2] = out2;
    assign outs[3] = out3;
    assign outs[4] = out4;
    assign outs[5] = out5;
    assign outs[6] = out6;
    assign outs[7] = out7;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // The block can take the word if it is out of reset and the addressed lane is empty or being drained.
    function automatic logic model_rdy();
        return rst_n && (!m_full[b] || out_ack[b]);
    endfunction

    function automatic logic [7:0] model_vld_vec();
        logic [7:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) v[k] = m_full[k];
        return v;
    endfunction

    // Apply the behaviour rules for one rising edge using the inputs currently driven.
    task automatic model_edge();
        logic take;
        take = in_vld && model_rdy();
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                m_dat[k]  = 16'h0000;
                m_full[k] = 1'b0;
            end
            m_cnt = 0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (take && (int'(b) == k)) begin
                    m_dat[k]  = in_data;
                    m_full[k] = 1'b1;
                end else if (out_ack[k]) begin
                    m_full[k] = 1'b0;
                end
            end
            if (take) m_cnt = (m_cnt + 1) % 65536;
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_vld"}, 16'(out_vld), 16'(model_vld_vec()));
        chk({tag, "_cnt"}, wr_cnt, 16'(m_cnt));
        for (int k = 0; k < 8; k++)
            chk($sformatf("%s_out%0d", tag, k), outs[k], m_dat[k]);
    endtask

    // One clock: check in_rdy before the edge, advance the model, check all outputs after it.
    task automatic step(input string tag, output logic stalled);
        #1;
        chk({tag, "_rdy"}, 16'(in_rdy), 16'(model_rdy()));
        stalled = in_vld && !model_rdy();
        @(posedge clk);
        model_edge();
        #1;
        check_state(tag);
    endtask

    task automatic step_fast();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    logic st;

    initial begin
        for (int k = 0; k < 8; k++) begin
            m_dat[k]  = 16'h0000;
            m_full[k] = 1'b0;
        end
        m_cnt   = 0;
        rst_n   = 1'b0;
        in_vld  = 1'b1;
        in_data = 16'hDEAD;
        b       = 3'd2;
        out_ack = 8'h00;
        @(posedge clk);
        #1;

        // T1: reset held two cycles with a pending write
        step("t1a", st);
        step("t1b", st);
        chk("t1_rdy_low", 16'(in_rdy), 16'h0000);
        chk("t1_vld_zero", 16'(out_vld), 16'h0000);

        // T2: single write to lane 3
        rst_n   = 1'b1;
        in_data = 16'hA5A5;
        b       = 3'd3;
        in_vld  = 1'b1;
        step("t2", st);
        in_vld = 1'b0;
        chk("t2_out3", out3, 16'hA5A5);
        chk("t2_vld", 16'(out_vld), 16'h0008);
        chk("t2_cnt", wr_cnt, 16'h0001);
        chk("t2_out0", out0, 16'h0000);

        // T3: backpressure on full lane 3, released by a same-cycle ack
        in_data = 16'h1234;
        b       = 3'd3;
        in_vld  = 1'b1;
        step("t3_stall", st);
        chk("t3_stall_rdy", 16'(in_rdy), 16'h0000);
        chk("t3_hold_out3", out3, 16'hA5A5);
        out_ack = 8'h08;
        #1;
        chk("t3_ack_rdy", 16'(in_rdy), 16'h0001);
        step("t3_go", st);
        out_ack = 8'h00;
        in_vld  = 1'b0;
        chk("t3_out3", out3, 16'h1234);
        chk("t3_vld3", 16'(out_vld[3]), 16'h0001);
        chk("t3_cnt", wr_cnt, 16'h0002);

        // T4: fill all lanes (lane 3 refilled back-to-back), stall on lane 5, then drain all
        for (int k = 0; k < 8; k++) begin
            in_data = 16'h1000 + 16'(k);
            b       = 3'(k);
            in_vld  = 1'b1;
            out_ack = (k == 3) ? 8'h08 : 8'h00;
            step($sformatf("t4_fill%0d", k), st);
        end
        out_ack = 8'h00;
        chk("t4_full", 16'(out_vld), 16'h00FF);
        in_data = 16'h5555;
        b       = 3'd5;
        step("t4_stall5", st);
        chk("t4_stall_flag", 16'(st), 16'h0001);
        chk("t4_out5_kept", out5, 16'h1005);
        in_vld  = 1'b0;
        out_ack = 8'hFF;
        step("t4_drain", st);
        out_ack = 8'h00;
        chk("t4_drained", 16'(out_vld), 16'h0000);
        for (int k = 0; k < 8; k++)
            chk($sformatf("t4_keep%0d", k), outs[k], 16'h1000 + 16'(k));

        // T5: reset with lanes 0/2/4/6 full and a write to lane 1 pending
        for (int k = 0; k < 8; k += 2) begin
            in_data = 16'h2000 + 16'(k);
            b       = 3'(k);
            in_vld  = 1'b1;
            step($sformatf("t5_fill%0d", k), st);
        end
        chk("t5_vld55", 16'(out_vld), 16'h0055);
        in_data = 16'hBEEF;
        b       = 3'd1;
        rst_n   = 1'b0;
        step("t5_rst", st);
        rst_n  = 1'b1;
        in_vld = 1'b0;
        chk("t5_vld", 16'(out_vld), 16'h0000);
        chk("t5_cnt", wr_cnt, 16'h0000);
        chk("t5_out1", out1, 16'h0000);

        // Random phase: random writes, acks and rare resets; stalled words are held
        st = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!st) begin
                in_vld  = ($urandom_range(3) != 0);
                b       = 3'($urandom_range(7));
                in_data = 16'($urandom);
            end
            out_ack = 8'($urandom);
            rst_n   = ($urandom_range(63) != 0);
            step("rnd", st);
        end

        // T6: counter wrap with a continuous refill stream on lane 0
        rst_n   = 1'b0;
        in_vld  = 1'b0;
        out_ack = 8'h00;
        step("t6_rst", st);
        rst_n   = 1'b1;
        in_vld  = 1'b1;
        b       = 3'd0;
        out_ack = 8'h01;
        for (int i = 0; i < 65535; i++) begin
            in_data = 16'(i);
            step_fast();
        end
        chk("t6_cnt_ffff", wr_cnt, 16'hFFFF);
        in_data = 16'h7777;
        step("t6_wrap", st);
        chk("t6_cnt_0000", wr_cnt, 16'h0000);
        chk("t6_out0", out0, 16'h7777);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
